tx_link_ctrl: RTL and testbench

//  Multi-lane JESD204B transmit link-layer controller: runs CGS -> ILA -> DATA sequencing on SYNC~.

---
 rtl/tx_link_ctrl.sv | 174 +++++++++++++++++
 tb/tb_tx_link_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_ctrl.sv
// Multi-lane transmit link-layer controller: CGS -> ILA -> DATA sequencing
// driven by SYNC~, with error-report and resync decoding.
module tx_link_ctrl #(
    parameter int LANES         = 4,
    parameter int RESYNC_FRAMES = 5,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_link_en,
    input  logic                   i_frame_strb,
    input  logic                   i_lmfc_strb,
    input  logic                   i_sync_n,
    input  logic [7:0]             i_F,
    input  logic [7:0]             i_ila_mf_len,
    input  logic [LANES-1:0]       i_lane_en,
    output logic [3*LANES-1:0]     o_link_mux,
    output logic [1:0]             o_state,
    output logic [7:0]             o_ila_mf_idx,
    output logic                   o_link_up,
    output logic                   o_err_pulse,
    output logic                   o_resync_pulse,
    output logic [ERR_CNT_W-1:0]   o_err_cnt
);

    typedef enum logic [1:0] {
        S_CGS  = 2'd0,
        S_WAIT = 2'd1,
        S_ILA  = 2'd2,
        S_DATA = 2'd3
    } state_t;

    localparam logic [3:0] LOW_THR = 4'(RESYNC_FRAMES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_kcnt;
    logic [3:0]           r_lowcnt;
    logic [3:0]           w_low_nxt;
    logic [3:0]           w_kmin;
    logic [7:0]           r_mf_idx;
    logic [7:0]           w_mf_nxt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_err_pulse;
    logic                 r_resync_pulse;
    logic                 r_sync_d;
    logic                 w_active;
    logic                 w_resync;
    logic                 w_err;
    logic [2:0]           w_code;

    always_comb begin
        w_kmin = 4'd2;
        unique case (1'b1)
            (i_F == 8'd0):                 w_kmin = 4'd10;
            (i_F == 8'd1):                 w_kmin = 4'd6;
            (i_F inside {8'd2, 8'd3}):     w_kmin = 4'd4;
            (i_F >= 8'd4 && i_F <= 8'd7):  w_kmin = 4'd3;
            default:                       w_kmin = 4'd2;
        endcase
    end

    always_comb begin
        w_low_nxt = r_lowcnt;
        if (i_sync_n)
            w_low_nxt = 4'd0;
        else if (i_frame_strb && r_lowcnt != 4'hf)
            w_low_nxt = r_lowcnt + 4'd1;
    end

    assign w_active = (r_state == S_ILA) || (r_state == S_DATA);
    assign w_resync = w_active && !i_sync_n && i_frame_strb
                    && (r_lowcnt == LOW_THR);
    // A rising edge with lowcnt=0 was shorter than a frame: ignored
    assign w_err = w_active && i_sync_n && !r_sync_d
                 && (r_lowcnt != 4'd0) && (r_lowcnt <= LOW_THR);

    always_comb begin
        w_state_nxt = r_state;
        w_mf_nxt    = r_mf_idx;
        if (!i_link_en) begin
            w_state_nxt = S_CGS;
            w_mf_nxt    = 8'd0;
        end else if (w_resync) begin
            w_state_nxt = S_CGS;
        end else begin
            unique case (r_state)
                S_CGS: begin
                    if (i_sync_n && r_kcnt >= w_kmin)
                        w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (!i_sync_n) begin
                        w_state_nxt = S_CGS;
                    end else if (i_lmfc_strb) begin
                        w_state_nxt = S_ILA;
                        w_mf_nxt    = 8'd0;
                    end
                end
                S_ILA: begin
                    if (i_lmfc_strb) begin
                        if (r_mf_idx == i_ila_mf_len)
                            w_state_nxt = S_DATA;
                        else
                            w_mf_nxt = r_mf_idx + 8'd1;
                    end
                end
                S_DATA: w_state_nxt = S_DATA;
                default: w_state_nxt = S_CGS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_CGS;
            r_mf_idx <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_mf_idx <= w_mf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kcnt         <= 4'd0;
            r_lowcnt       <= 4'd0;
            r_err_cnt      <= '0;
            r_err_pulse    <= 1'b0;
            r_resync_pulse <= 1'b0;
            r_sync_d       <= 1'b1;
        end else begin
            r_sync_d       <= i_sync_n;
            r_err_pulse    <= i_link_en && w_err;
            r_resync_pulse <= i_link_en && w_resync;
            if (!i_link_en) begin
                r_kcnt    <= 4'd0;
                r_lowcnt  <= 4'd0;
                r_err_cnt <= '0;
            end else begin
                r_lowcnt <= w_low_nxt;
                if (r_state != S_CGS)
                    r_kcnt <= 4'd0;
                else if (i_frame_strb && r_kcnt != 4'hf)
                    r_kcnt <= r_kcnt + 4'd1;
                if (w_err && !(&r_err_cnt))
                    r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_code = 3'd1;
        unique case (r_state)
            S_ILA:   w_code = 3'd2;
            S_DATA:  w_code = 3'd0;
            default: w_code = 3'd1;
        endcase
    end

    always_comb begin
        o_link_mux = '0;
        for (int n = 0; n < LANES; n++)
            o_link_mux[3*n +: 3] = i_lane_en[n] ? w_code : 3'd1;
    end

    assign o_state        = r_state;
    assign o_ila_mf_idx   = r_mf_idx;
    assign o_link_up      = (r_state == S_DATA);
    assign o_err_pulse    = r_err_pulse;
    assign o_resync_pulse = r_resync_pulse;
    assign o_err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Bench for tx_link_ctrl: directed scenarios plus random SYNC~ traffic,
// checked every cycle against a frame-level reference model.
module tb_tx_link_ctrl;

    localparam int LANES = 4;
    localparam int RSF   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_link_en;
    logic             i_frame_strb;
    logic             i_lmfc_strb;
    logic             i_sync_n;
    logic [7:0]       i_F;
    logic [7:0]       i_ila_mf_len;
    logic [LANES-1:0] i_lane_en;
    logic [11:0]      o_link_mux;
    logic [1:0]       o_state;
    logic [7:0]       o_ila_mf_idx;
    logic             o_link_up;
    logic             o_err_pulse;
    logic             o_resync_pulse;
    logic [7:0]       o_err_cnt;

    tx_link_ctrl #(
        .LANES(LANES), .RESYNC_FRAMES(RSF), .ERR_CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_link_en(i_link_en),
        .i_frame_strb(i_frame_strb),
        .i_lmfc_strb(i_lmfc_strb),
        .i_sync_n(i_sync_n),
        .i_F(i_F),
        .i_ila_mf_len(i_ila_mf_len),
        .i_lane_en(i_lane_en),
        .o_link_mux(o_link_mux),
        .o_state(o_state),
        .o_ila_mf_idx(o_ila_mf_idx),
        .o_link_up(o_link_up),
        .o_err_pulse(o_err_pulse),
        .o_resync_pulse(o_resync_pulse),
        .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: 0 CGS, 1 WAIT_LMFC, 2 ILA, 3 DATA
    int m_state, m_k, m_low, m_mf, m_err;
    bit m_errp, m_rsp, m_prev;

    function automatic int kmin_of(input logic [7:0] fm1);
        int f;
        f = int'(fm1) + 1;
        if (f == 1) return 10;
        if (f == 2) return 6;
        if (f <= 4) return 4;
        if (f <= 8) return 3;
        return 2;
    endfunction

    task automatic model_reset();
        m_state = 0; m_k = 0; m_low = 0; m_mf = 0; m_err = 0;
        m_errp = 0; m_rsp = 0; m_prev = 1;
    endtask

    task automatic model_edge();
        int ns, nmf, lown, nk;
        bit act, rise, rs, er;
        act  = (m_state >= 2);
        rise = i_sync_n && !m_prev;
        if (i_sync_n) lown = 0;
        else if (i_frame_strb) lown = (m_low < 15) ? m_low + 1 : 15;
        else lown = m_low;
        rs = act && lown == RSF && m_low < RSF;
        er = act && rise && m_low >= 1 && m_low < RSF;
        ns = m_state; nmf = m_mf;
        if (!i_link_en) begin
            ns = 0; nmf = 0;
        end else if (rs) begin
            ns = 0;
        end else if (m_state == 0) begin
            if (i_sync_n && m_k >= kmin_of(i_F)) ns = 1;
        end else if (m_state == 1) begin
            if (!i_sync_n) ns = 0;
            else if (i_lmfc_strb) begin ns = 2; nmf = 0; end
        end else if (m_state == 2 && i_lmfc_strb) begin
            if (m_mf == int'(i_ila_mf_len)) ns = 3;
            else nmf = m_mf + 1;
        end
        if (!i_link_en || m_state != 0) nk = 0;
        else nk = (m_k + int'(i_frame_strb) > 15) ? 15
                : m_k + int'(i_frame_strb);
        if (!i_link_en) m_err = 0;
        else if (er && m_err < 255) m_err++;
        m_errp  = i_link_en && er;
        m_rsp   = i_link_en && rs;
        m_low   = i_link_en ? lown : 0;
        m_prev  = i_sync_n;
        m_k     = nk;
        m_state = ns;
        m_mf    = nmf;
    endtask

    function automatic logic [32:0] act_vec();
        return {o_state, o_link_mux, o_ila_mf_idx, o_link_up,
                o_err_pulse, o_resync_pulse, o_err_cnt};
    endfunction

    function automatic logic [32:0] exp_vec();
        logic [11:0] mx;
        logic [2:0]  code;
        code = (m_state == 3) ? 3'd0 : (m_state == 2) ? 3'd2 : 3'd1;
        for (int n = 0; n < LANES; n++)
            mx[3*n +: 3] = i_lane_en[n] ? code : 3'd1;
        return {2'(m_state), mx, 8'(m_mf), 1'(m_state == 3),
                m_errp, m_rsp, 8'(m_err)};
    endfunction

    task automatic step();
        i_frame_strb = (cyc % 4 == 3);
        i_lmfc_strb  = (cyc % 16 == 15);
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        cyc++;
    endtask

    task automatic bring_up(input int len, input logic [7:0] f,
                            input int stop, output logic [3:0] mask,
                            output logic [11:0] ila_mux);
        bit done, got;
        mask = '0; ila_mux = '0; done = 0; got = 0;
        i_F = f; i_ila_mf_len = 8'(len);
        i_link_en = 0; i_sync_n = 0;
        step();
        i_link_en = 1;
        for (int k = 0; k < 1048 && !done; k++) begin
            if (k == 48) i_sync_n = 1;
            step();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL bringup cyc=%0d got=%h exp=%h",
                         cyc, act_vec(), exp_vec());
            end
            if (o_state == 2'd2) begin
                if (o_ila_mf_idx < 8'd4) mask[o_ila_mf_idx[1:0]] = 1'b1;
                if (!got) begin ila_mux = o_link_mux; got = 1; end
            end
            if (k >= 48 && int'(o_state) == stop) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL bringup_timeout state=%0d want=%0d",
                     o_state, stop);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; i_link_en = 0; i_sync_n = 0;
        i_F = 0; i_ila_mf_len = 0; i_lane_en = 4'hf;
        i_frame_strb = 0; i_lmfc_strb = 0;
        model_reset();
        #2;
        repeat (3) begin
            step();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset got=%h exp=%h", act_vec(), exp_vec());
            end
        end
        total++;
        if (o_link_mux !== 12'h249) begin
            bad++;
            $display("FAIL reset_mux got=%h exp=249", o_link_mux);
        end
        rst_n = 1;
    endtask

    task automatic test_bringup();
        logic [3:0]  mask;
        logic [11:0] im;
        bring_up(3, 8'd0, 3, mask, im);
        total++;
        if (mask !== 4'hf) begin
            bad++;
            $display("FAIL ila_idx_seen got=%b exp=1111", mask);
        end
        total++;
        if ({o_link_up, o_link_mux} !== {1'b1, 12'h000}) begin
            bad++;
            $display("FAIL data_up got=%b/%h exp=1/000",
                     o_link_up, o_link_mux);
        end
    endtask

    task automatic test_err();
        int np;
        np = 0;
        i_sync_n = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) i_sync_n = 1;
            step();
            np += int'(o_err_pulse);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL err_one cyc=%0d got=%h exp=%h",
                         cyc, act_vec(), exp_vec());
            end
        end
        total++;
        if (np != 1 || o_err_cnt !== 8'd1 || o_state !== 2'd3) begin
            bad++;
            $display("FAIL err_report got=%0d/%0d/%0d exp=1/1/3",
                     np, o_err_cnt, o_state);
        end
        for (int r = 0; r < 300; r++) begin
            for (int k = 0; k < 5; k++) begin
                i_sync_n = (k == 4);
                step();
                total++;
                if (act_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL err_burst cyc=%0d got=%h exp=%h",
                             cyc, act_vec(), exp_vec());
                end
            end
        end
        total++;
        if (o_err_cnt !== 8'd255 || o_state !== 2'd3) begin
            bad++;
            $display("FAIL err_sat got=%0d/%0d exp=255/3",
                     o_err_cnt, o_state);
        end
    endtask

    task automatic test_resync();
        int np;
        bit cgs_at_pulse;
        np = 0; cgs_at_pulse = 0;
        i_sync_n = 0;
        repeat (20) begin
            step();
            if (o_resync_pulse) begin
                np++;
                cgs_at_pulse = (o_state == 2'd0);
            end
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL resync cyc=%0d got=%h exp=%h",
                         cyc, act_vec(), exp_vec());
            end
        end
        total++;
        if (np != 1 || !cgs_at_pulse || o_link_mux !== 12'h249
            || o_link_up !== 1'b0) begin
            bad++;
            $display("FAIL resync_end got=%0d/%0d/%h/%b exp=1/1/249/0",
                     np, cgs_at_pulse, o_link_mux, o_link_up);
        end
        i_sync_n = 1;
    endtask

    task automatic test_lane_en();
        logic [3:0]  mask;
        logic [11:0] im;
        i_lane_en = 4'b0101;
        bring_up(1, 8'd3, 3, mask, im);
        total++;
        if (im !== 12'h28a) begin
            bad++;
            $display("FAIL lane_ila got=%h exp=28a", im);
        end
        total++;
        if (o_link_mux !== 12'h208) begin
            bad++;
            $display("FAIL lane_data got=%h exp=208", o_link_mux);
        end
        i_lane_en = 4'hf;
    endtask

    task automatic test_collision();
        logic [3:0]  mask;
        logic [11:0] im;
        int nup, nrs;
        bit found;
        nup = 0; nrs = 0; found = 0;
        bring_up(3, 8'd1, 2, mask, im);
        for (int k = 0; k < 200 && !found; k++) begin
            if (o_state == 2'd2 && o_ila_mf_idx == 8'd2
                && cyc % 16 == 12) found = 1;
            else begin
                step();
                total++;
                if (act_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL coll_pre got=%h exp=%h",
                             act_vec(), exp_vec());
                end
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL coll_align_timeout idx=%0d", o_ila_mf_idx);
        end
        i_sync_n = 0;
        repeat (20) begin
            step();
            nup += int'(o_link_up);
            nrs += int'(o_resync_pulse);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL coll cyc=%0d got=%h exp=%h",
                         cyc, act_vec(), exp_vec());
            end
        end
        total++;
        if (nup != 0 || nrs != 1 || o_state !== 2'd0) begin
            bad++;
            $display("FAIL coll_end got=%0d/%0d/%0d exp=0/1/0",
                     nup, nrs, o_state);
        end
        i_sync_n = 1;
        bring_up(3, 8'd1, 2, mask, im);
        for (int k = 0; k < 24; k++) begin
            i_sync_n = !(k >= 2 && k < 6);
            step();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL linkdis_pre got=%h exp=%h",
                         act_vec(), exp_vec());
            end
        end
        i_link_en = 0;
        step();
        total++;
        if (o_state !== 2'd0 || o_ila_mf_idx !== 8'd0
            || o_err_cnt !== 8'd0 || act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL linkdis got=%h exp=%h", act_vec(), exp_vec());
        end
        i_link_en = 1;
    endtask

    task automatic test_async_reset();
        logic [3:0]  mask;
        logic [11:0] im;
        bring_up(1, 8'd7, 3, mask, im);
        #3 rst_n = 0;
        #1;
        model_reset();
        total++;
        if (act_vec() !== exp_vec() || o_link_mux !== 12'h249) begin
            bad++;
            $display("FAIL async_rst got=%h exp=%h", act_vec(), exp_vec());
        end
        repeat (3) step();
        rst_n = 1;
        bring_up(2, 8'd0, 3, mask, im);
        total++;
        if (o_link_up !== 1'b1 || mask !== 4'b0111) begin
            bad++;
            $display("FAIL async_rerun got=%b/%b exp=1/0111",
                     o_link_up, mask);
        end
    endtask

    task automatic test_random();
        int low_left, off_left;
        low_left = 0; off_left = 0;
        for (int k = 0; k < 4000; k++) begin
            if (off_left > 0) begin
                off_left--;
                if (off_left == 0) begin
                    i_F = 8'($urandom_range(0, 20));
                    i_ila_mf_len = 8'($urandom_range(0, 3));
                    i_link_en = 1;
                end
            end else if ($urandom_range(0, 499) == 0) begin
                i_link_en = 0;
                off_left = $urandom_range(1, 6);
            end
            if (low_left > 0) begin
                low_left--;
                i_sync_n = (low_left == 0);
            end else if ($urandom_range(0, 29) == 0) begin
                low_left = $urandom_range(1, 28);
                i_sync_n = 0;
            end
            if ($urandom_range(0, 99) == 0)
                i_lane_en = 4'($urandom);
            step();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h",
                         cyc, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_err();
        test_resync();
        test_lane_en();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
